td4_mem_dump: RTL and testbench

TD4_MEM_DUMP -- requirements
Module: td4_mem_dump

---
 rtl/td4_pkg.sv | 30 +++
 rtl/td4_mem_dump_if.sv | 25 ++
 rtl/td4_uart_tx.sv | 110 +++++++++++
 rtl/td4_mem_dump.sv | 115 +++++++++++
 tb/tb_td4_mem_dump.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/td4_pkg.sv
// Shared constants, state/phase encodings and the word-packing helper for the
// TD4 program-memory dumper.
package td4_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam logic [3:0]  LAST_ADDR = 4'(NUM_WORDS - 1);

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FETCH     = 3'd1;
  localparam state_t ST_LOAD      = 3'd2;
  localparam state_t ST_START_BIT = 3'd3;
  localparam state_t ST_DATA      = 3'd4;
  localparam state_t ST_STOP_BIT  = 3'd5;
  localparam state_t ST_FINISH    = 3'd6;

  typedef logic [1:0] phase_t;
  localparam phase_t PH_IDLE  = 2'd0;
  localparam phase_t PH_START = 2'd1;
  localparam phase_t PH_DATA  = 2'd2;
  localparam phase_t PH_STOP  = 2'd3;

  // Opcode occupies the upper nibble of the transmitted byte.
  function automatic logic [7:0] pack_word(input logic [3:0] opcode, input logic [3:0] immediate);
    return {opcode, immediate};
  endfunction

endpackage

// File: rtl/td4_mem_dump_if.sv
// Bus bundle between the dumper and its host: start request, program-memory
// read port, serial line and status.
interface td4_mem_dump_if;
  import td4_pkg::*;

  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        rd_opcode;
  logic [3:0]        rd_immediate;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output start, rd_opcode, rd_immediate,
    input  rd_en, rd_addr, tx, busy, done
  );

  modport slave (
    input  start, rd_opcode, rd_immediate,
    output rd_en, rd_addr, tx, busy, done
  );

endinterface

// File: rtl/td4_uart_tx.sv
// 8N1 LSB-first serializer; accepts a byte on load_i while ready_o is high.
module td4_uart_tx
  import td4_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tick_o,
  output logic       last_bit_o,
  output logic       tx_o
);

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  phase_t     phase_q, phase_d;
  logic [7:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       tick_s;

  assign tick_s     = (phase_q != PH_IDLE) && (baud_q == BAUD_LAST);
  assign ready_o    = (phase_q == PH_IDLE);
  assign tick_o     = tick_s;
  assign last_bit_o = (bit_q == BIT_LAST);
  assign tx_o       = tx_q;

  // Phase sequencing; tx_d is the line level for the next cycle.
  always_comb begin
    phase_d = phase_q;
    baud_d  = baud_q + 8'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (phase_q)
      PH_IDLE: begin
        baud_d = 8'd0;
        if (load_i) begin
          phase_d = PH_START;
          shift_d = data_i;
          tx_d    = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      PH_START: begin
        if (tick_s) begin
          phase_d = PH_DATA;
          baud_d  = 8'd0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          tx_d = 1'b0;
        end
      end
      PH_DATA: begin
        if (tick_s) begin
          baud_d = 8'd0;
          if (bit_q == BIT_LAST) begin
            phase_d = PH_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          tx_d = tx_q;
        end
      end
      PH_STOP: begin
        tx_d = 1'b1;
        if (tick_s) begin
          phase_d = PH_IDLE;
          baud_d  = 8'd0;
        end else begin
          phase_d = PH_STOP;
        end
      end
      default: begin
        phase_d = PH_IDLE;
        baud_d  = 8'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Serializer state; reset drives the line idle-high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      baud_q  <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      phase_q <= phase_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/td4_mem_dump.sv
// Dumps all 16 TD4 program words over a UART, ascending from address 0,
// with registered read-strobe and status outputs.
module td4_mem_dump
  import td4_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  td4_mem_dump_if.slave bus
);

  state_t     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] rd_addr_q, rd_addr_d;
  logic       rd_en_q, busy_q, done_q;
  logic       load_s, ready_s, tick_s, last_bit_s, tx_s;
  logic [7:0] word_s;

  assign word_s = pack_word(bus.rd_opcode, bus.rd_immediate);
  assign load_s = (state_q == ST_LOAD) && ready_s;

  td4_uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_s),
    .data_i     (word_s),
    .ready_o    (ready_s),
    .tick_o     (tick_s),
    .last_bit_o (last_bit_s),
    .tx_o       (tx_s)
  );

  // Dump sequencing. A start held through FINISH re-enters FETCH directly so
  // back-to-back dumps lose only the single FINISH cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
          addr_d  = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        if (ready_s) state_d = ST_START_BIT;
        else         state_d = ST_LOAD;
      end
      ST_START_BIT: begin
        if (tick_s) state_d = ST_DATA;
        else        state_d = ST_START_BIT;
      end
      ST_DATA: begin
        if (tick_s && last_bit_s) state_d = ST_STOP_BIT;
        else                      state_d = ST_DATA;
      end
      ST_STOP_BIT: begin
        if (!tick_s) begin
          state_d = ST_STOP_BIT;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_FETCH;
          addr_d  = addr_q + 4'd1;
        end
      end
      ST_FINISH: begin
        if (bus.start) begin
          state_d = ST_FETCH;
          addr_d  = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = 4'd0;
      end
    endcase
  end

  assign rd_addr_d = (state_d == ST_FETCH) ? addr_d : rd_addr_q;

  // Outputs are decoded from the next state so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= 4'd0;
      rd_addr_q <= 4'd0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= (state_d == ST_FETCH);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_FINISH);
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.tx      = tx_s;

endmodule

// File: tb/tb_td4_mem_dump.sv
// Directed bench for td4_mem_dump at CLKS_PER_BIT=4: memory model, UART
// decoder and hand-computed timing expectations.
module tb_td4_mem_dump;
  import td4_pkg::*;

  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  td4_mem_dump_if bus ();

  td4_mem_dump #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [16];

  // Program memory: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_opcode    <= mem[bus.rd_addr][7:4];
      bus.rd_immediate <= mem[bus.rd_addr][3:0];
    end
  end

  int         addr_q[$];
  int         done_q[$];
  logic [7:0] byte_q[$];
  int         rd_en_dbl = 0;
  int         stop_err  = 0;
  logic       rd_en_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.rd_en) addr_q.push_back(int'(bus.rd_addr));
    if (bus.done) done_q.push_back(cyc);
    if (bus.rd_en && rd_en_prev) rd_en_dbl <= rd_en_dbl + 1;
    rd_en_prev <= bus.rd_en;
  end

  // Frame decoder for 4 clocks per bit: mid-bit sampling relative to the
  // first low sample of the start bit.
  logic       dec_act = 1'b0;
  int         dec_rel = 0;
  logic [7:0] dec_byte = 8'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      dec_act <= 1'b0;
      dec_rel <= 0;
    end else if (!dec_act) begin
      if (!bus.tx) begin
        dec_act <= 1'b1;
        dec_rel <= 0;
      end
    end else begin
      dec_rel <= dec_rel + 1;
      if (dec_rel >= 5 && dec_rel <= 33 && ((dec_rel - 5) % 4) == 0)
        dec_byte <= {bus.tx, dec_byte[7:1]};
      if (dec_rel == 37) begin
        byte_q.push_back(dec_byte);
        if (!bus.tx) stop_err <= stop_err + 1;
        dec_act <= 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n);
    logic [3:0] a;
    a = 4'(n);
    return {a, ~a};
  endfunction

  task automatic clear_logs();
    addr_q.delete();
    done_q.delete();
    byte_q.delete();
  endtask

  task automatic pulse_start(output int t0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_seq(input string tag, input int n);
    int bad_b = 0;
    int bad_a = 0;
    check({tag, "_nbytes"}, byte_q.size(), n);
    check({tag, "_nrd_en"}, addr_q.size(), n);
    for (int i = 0; i < byte_q.size(); i++)
      if (byte_q[i] !== exp_byte(i % 16)) bad_b++;
    for (int i = 0; i < addr_q.size(); i++)
      if (addr_q[i] != (i % 16)) bad_a++;
    check({tag, "_byte_errs"}, bad_b, 32'd0);
    check({tag, "_addr_errs"}, bad_a, 32'd0);
  endtask

  task automatic check_done(input string tag, input int t0, input int n);
    check({tag, "_ndone"}, done_q.size(), n);
    if (done_q.size() > 0) check({tag, "_done_lat"}, done_q[0] - t0, 32'd672);
    else                   check({tag, "_done_lat"}, 32'hFFFF_FFFF, 32'd672);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t0;
    int         lows;
    int         nd;
    logic [7:0] fb;
    logic       exp_tx;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = exp_byte(i);
    repeat (3) @(negedge clk);

    check("rst_tx",      32'(bus.tx),      32'd1);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_rd_en",   32'(bus.rd_en),   32'd0);
    check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Single-frame waveform with address 0 holding 0xA5.
    mem[0] = 8'hA5;
    fb     = 8'hA5;
    pulse_start(t0);
    check("a_fetch_rd_en", 32'(bus.rd_en),   32'd1);
    check("a_fetch_addr",  32'(bus.rd_addr), 32'd0);
    check("a_fetch_busy",  32'(bus.busy),    32'd1);
    check("a_fetch_tx",    32'(bus.tx),      32'd1);
    for (int t = 1; t < 42; t++) begin
      @(negedge clk);
      if (t < 2)       exp_tx = 1'b1;
      else if (t < 6)  exp_tx = 1'b0;
      else if (t < 38) exp_tx = fb[(t - 6) / 4];
      else             exp_tx = 1'b1;
      check($sformatf("a_tx_t%0d", t), 32'(bus.tx), 32'(exp_tx));
      if (t == 1) check("a_load_rd_en", 32'(bus.rd_en), 32'd0);
    end
    @(negedge clk);
    check("a_next_addr", 32'(bus.rd_addr), 32'd1);
    wait_idle("a", 1000);
    check_done("a", t0, 1);
    check("a_nbytes", byte_q.size(), 32'd16);
    if (byte_q.size() == 16) begin
      check("a_byte0",  32'(byte_q[0]),  32'hA5);
      check("a_byte15", 32'(byte_q[15]), 32'hF0);
    end
    mem[0] = exp_byte(0);

    // Full dump of the {n, ~n} pattern.
    clear_logs();
    pulse_start(t0);
    wait_idle("b", 1000);
    check_seq("b", 16);
    check_done("b", t0, 1);

    // A second start pulse mid-dump must be ignored.
    clear_logs();
    pulse_start(t0);
    repeat (99) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("c", 1000);
    check_seq("c", 16);
    check_done("c", t0, 1);
    repeat (10) @(negedge clk);
    check("c_no_restart", 32'(bus.busy), 32'd0);

    // Reset during data bit 0 of byte 5 (0x5A, bit 0 low).
    clear_logs();
    pulse_start(t0);
    repeat (217) @(negedge clk);
    check("d_pre_tx",     32'(bus.tx),    32'd0);
    check("d_pre_nbytes", byte_q.size(), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    check("d_rst_tx",    32'(bus.tx),    32'd1);
    check("d_rst_busy",  32'(bus.busy),  32'd0);
    check("d_rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("d_rst_done",  32'(bus.done),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows  = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (!bus.tx || bus.busy) lows++;
    end
    check("d_quiet_after_rst", lows, 32'd0);
    check("d_no_done",         done_q.size(), 32'd0);
    check("d_aborted_nbytes",  byte_q.size(), 32'd5);
    clear_logs();
    pulse_start(t0);
    wait_idle("d2", 1000);
    check_seq("d2", 16);
    check_done("d2", t0, 1);

    // Start held high: back-to-back dumps.
    clear_logs();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    nd = 0;
    for (int i = 0; i < 2500 && nd < 3; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    bus.start = 1'b0;
    wait_idle("e", 1000);
    check_done("e", t0, 3);
    if (done_q.size() >= 3) begin
      check("e_period1", done_q[1] - done_q[0], 32'd673);
      check("e_period2", done_q[2] - done_q[1], 32'd673);
    end
    check_seq("e", 48);

    check("rd_en_single_cycle", rd_en_dbl, 32'd0);
    check("stop_bits_high",     stop_err,  32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
